// File: rtl/seq_divider.sv
// Multi-cycle unsigned radix-2 restoring divider; responder end of the Busy/Ready divide handshake.
// Optional round-to-nearest quotient stage is enabled by defining DIVIDER_ROUNDING_EN.
module seq_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             Busy,
    output logic             Ready,
    output logic             div_zero,
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted on an edge where Busy is low (IDLE or DONE) and the operands
    // are latched on that edge; Busy stays high until results are written, and Ready is high
    // for exactly the one cycle in which the new results first appear. start while Busy is dropped.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
`ifdef DIVIDER_ROUNDING_EN
        DONE  = 2'd2,
        ROUND = 2'd3
`else
        DONE  = 2'd2
`endif
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CNT_W-1:0] cnt;
    logic             dz_reg;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   r_shift;
    logic             r_ge;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (cnt == CNT_W'(1));

    // The partial remainder never exceeds the divisor after a step, so WIDTH bits hold it;
    // only the shifted trial value needs the extra bit for the comparison.
    assign r_shift = {r_reg, q_reg[WIDTH-1]};
    assign r_ge    = (r_shift >= {1'b0, d_reg});
    assign r_nx    = r_ge ? (r_shift[WIDTH-1:0] - d_reg) : r_shift[WIDTH-1:0];
    assign q_nx    = {q_reg[WIDTH-2:0], r_ge};

`ifdef DIVIDER_ROUNDING_EN
    logic round_up;
    assign round_up = ({r_reg, 1'b0} >= {1'b0, d_reg}) && !dz_reg && (q_reg != '1);
    assign Busy     = (state == CALC) || (state == ROUND);
`else
    assign Busy     = (state == CALC);
`endif
    assign Ready     = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: begin
                if (last_step) begin
`ifdef DIVIDER_ROUNDING_EN
                    state_nx = ROUND;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef DIVIDER_ROUNDING_EN
            ROUND: state_nx = DONE;
`endif
            DONE: state_nx = start ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            q_reg     <= '0;
            d_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
            dz_reg    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                q_reg  <= dividend;
                d_reg  <= divisor;
                r_reg  <= '0;
                cnt    <= CNT_W'(WIDTH);
                dz_reg <= (divisor == '0);
            end else if (state == CALC) begin
                q_reg <= q_nx;
                r_reg <= r_nx;
                cnt   <= cnt - 1'b1;
            end
`ifdef DIVIDER_ROUNDING_EN
            if (state == ROUND) begin
                quotient  <= round_up ? (q_reg + 1'b1) : q_reg;
                remainder <= r_reg;
                div_zero  <= dz_reg;
            end
`else
            // A zero divisor needs no special path: every trial subtract succeeds, giving
            // an all-ones quotient with the dividend left in the remainder.
            if ((state == CALC) && last_step) begin
                quotient  <= q_nx;
                remainder <= r_nx;
                div_zero  <= dz_reg;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized bench for seq_divider, checked against a plain-arithmetic model.
module tb_seq_divider;

    localparam int W = 16;
`ifdef DIVIDER_ROUNDING_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         ready;
    logic         div_zero;
    logic [1:0]   dbg_state;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .Busy(busy), .Ready(ready), .div_zero(div_zero),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: integer division, with the zero-divisor and round-to-nearest rules on top.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        int unsigned ua, ub, uq, ur;
        ua = a;
        ub = b;
        if (ub == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
`ifdef DIVIDER_ROUNDING_EN
            if ((2 * ur >= ub) && (uq != (1 << W) - 1)) uq = uq + 1;
`endif
            q  = W'(uq);
            r  = W'(ur);
            dz = 1'b0;
        end
    endtask

    // Present a request for one edge, then scramble the operand inputs.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Called one step after the accepting edge; returns with Ready visible (or budget spent).
    task automatic wait_check(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eq, er;
        logic         edz;
        int           lat, busy_n;
        model(a, b, eq, er, edz);
        lat    = 0;
        busy_n = 0;
        while (!ready && lat < LAT + 10) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_busy_cycles"}, busy_n, LAT);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_div_zero"}, div_zero, edz);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        start_op(a, b);
        wait_check(a, b, tag);
        @(posedge clk);
        #1;
        chk({tag, "_ready_drop"}, ready, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           rc, bad;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", ready, 0);
        chk("reset_div_zero", div_zero, 0);
        rst = 1'b0;

        do_op(16'd1000, 16'd7, "div_1000_7");
        do_op(16'd65535, 16'd1, "div_65535_1");
        do_op(16'd3, 16'd65535, "div_3_65535");
        do_op(16'd5, 16'd0, "div_by_zero");
        do_op(16'd10, 16'd3, "div_10_3");
        do_op(16'd0, 16'd5, "div_0_5");
        do_op(16'd1234, 16'd1, "div_by_one");

        // start while busy must be ignored
        start_op(16'd100, 16'd9);
        rc = 0;
        for (int i = 1; i <= W + 8; i++) begin
            if (i == 3) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 16'd5;
            end
            if (i == 4) start = 1'b0;
            @(posedge clk);
            #1;
            if (ready) rc++;
        end
        chk("ignore_start_ready_pulses", rc, 1);
        chk("ignore_start_quotient", quotient, 11);
        chk("ignore_start_remainder", remainder, 1);

        // reset mid-operation discards the result
        start_op(16'd1000, 16'd7);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        bad = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (ready) bad++;
        end
        chk("midrst_no_ready", bad, 0);
        do_op(16'd20, 16'd4, "after_rst_20_4");

        // back-to-back request during the DONE cycle
        start_op(16'd1000, 16'd7);
        wait_check(16'd1000, 16'd7, "b2b_first");
        start    = 1'b1;
        dividend = 16'd200;
        divisor  = 16'd8;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        chk("b2b_ready_drop", ready, 0);
        chk("b2b_busy", busy, 1);
        wait_check(16'd200, 16'd8, "b2b_second");
        @(posedge clk);
        #1;

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = W'($urandom_range(0, 20));
                1:       rb = ra + W'($urandom_range(0, 3));
                default: rb = W'($urandom);
            endcase
            do_op(ra, rb, $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
